// File: rtl/mouse_pos_tracker_if.sv
// Bus between the PS/2 byte receiver and the cursor tracker.
// rx_valid is a one-cycle strobe with no back-pressure: the tracker samples every strobed byte and never stalls.
interface mouse_pos_tracker_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        right;
    logic        upd;
    logic        sync_err;
    logic [1:0]  dbg_state;

    modport master (
        output rx_data, rx_valid,
        input  xpos, ypos, left, right, upd, sync_err, dbg_state
    );

    modport slave (
        input  rx_data, rx_valid,
        output xpos, ypos, left, right, upd, sync_err, dbg_state
    );
endinterface

// File: rtl/mouse_pos_tracker.sv
// Frames PS/2 mouse bytes into 3-byte packets and integrates the deltas into a
// screen-clamped cursor position with button states.
module mouse_pos_tracker #(
    parameter int XMAX        = 1280,
    parameter int YMAX        = 720,
    parameter int X_INIT      = 640,
    parameter int Y_INIT      = 360,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk100MHz,
    input  logic              rst_n,
    mouse_pos_tracker_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]     TLIM = CW'(TIMEOUT_CYC - 1);
    localparam logic signed [13:0] XLIM = 14'(XMAX - 1);
    localparam logic signed [13:0] YLIM = 14'(YMAX - 1);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    b0, b1, b2;
    logic [CW-1:0] tcnt;
    logic [11:0]   xpos_q, ypos_q;
    logic          left_q, right_q, upd_q, sync_err_q;

    logic signed [13:0] dx, dy, nx, ny;
    logic [11:0]        nx_c, ny_c;

    // PS/2 +y points up while screen rows grow downward, hence the subtraction for ny.
    always_comb begin
        dx = b0[6] ? 14'sd0 : {{5{b0[4]}}, b0[4], b1};
        dy = b0[7] ? 14'sd0 : {{5{b0[5]}}, b0[5], b2};
        nx = $signed({2'b00, xpos_q}) + dx;
        ny = $signed({2'b00, ypos_q}) - dy;
        if (nx < 14'sd0)     nx_c = 12'd0;
        else if (nx > XLIM)  nx_c = XLIM[11:0];
        else                 nx_c = nx[11:0];
        if (ny < 14'sd0)     ny_c = 12'd0;
        else if (ny > YLIM)  ny_c = YLIM[11:0];
        else                 ny_c = ny[11:0];
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_B0;
            b0         <= 8'd0;
            b1         <= 8'd0;
            b2         <= 8'd0;
            tcnt       <= '0;
            xpos_q     <= 12'(X_INIT);
            ypos_q     <= 12'(Y_INIT);
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            upd_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            upd_q      <= 1'b0;
            sync_err_q <= 1'b0;
            case (state)
                WAIT_B0: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data[3]) begin
                            b0    <= bus.rx_data;
                            tcnt  <= '0;
                            state <= WAIT_B1;
                        end else begin
                            sync_err_q <= 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (bus.rx_valid) begin
                        b1    <= bus.rx_data;
                        tcnt  <= '0;
                        state <= WAIT_B2;
                    end else if (tcnt == TLIM) begin
                        tcnt       <= '0;
                        sync_err_q <= 1'b1;
                        state      <= WAIT_B0;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                WAIT_B2: begin
                    if (bus.rx_valid) begin
                        b2    <= bus.rx_data;
                        tcnt  <= '0;
                        state <= UPDATE;
                    end else if (tcnt == TLIM) begin
                        tcnt       <= '0;
                        sync_err_q <= 1'b1;
                        state      <= WAIT_B0;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                UPDATE: begin
                    xpos_q  <= nx_c;
                    ypos_q  <= ny_c;
                    left_q  <= b0[0];
                    right_q <= b0[1];
                    upd_q   <= 1'b1;
                    state   <= WAIT_B0;
                    // A byte arriving here is the next packet's header candidate; judge it like WAIT_B0.
                    if (bus.rx_valid) begin
                        if (bus.rx_data[3]) begin
                            b0    <= bus.rx_data;
                            tcnt  <= '0;
                            state <= WAIT_B1;
                        end else begin
                            sync_err_q <= 1'b1;
                        end
                    end
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

    assign bus.xpos      = xpos_q;
    assign bus.ypos      = ypos_q;
    assign bus.left      = left_q;
    assign bus.right     = right_q;
    assign bus.upd       = upd_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed bench for mouse_pos_tracker: framing, latency, clamping, timeout,
// overflow and back-to-back packets.
module tb_mouse_pos_tracker;
    localparam int TOUT = 40;

    logic clk100MHz;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;
    int   upd_cnt;
    int   err_cnt;
    int   upd_base;
    int   err_base;
    int   hit_idx;

    mouse_pos_tracker_if bus ();

    mouse_pos_tracker #(
        .XMAX(1280), .YMAX(720), .X_INIT(640), .Y_INIT(360), .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    // clock / reset
    initial clk100MHz = 1'b0;
    always #5 clk100MHz = ~clk100MHz;

    // pulse monitor
    always @(negedge clk100MHz) begin
        if (bus.upd)      upd_cnt++;
        if (bus.sync_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk100MHz);
    endtask

    // Called at a negedge; byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk100MHz);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        send_byte(p0);
        send_byte(p1);
        send_byte(p2);
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk100MHz);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        logic [11:0] ytab [0:7];
        total_cnt = 0;
        pass_cnt  = 0;
        upd_cnt   = 0;
        err_cnt   = 0;
        hit_idx   = -1;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        rst_n = 1'b1;
        do_reset();

        // reset state
        check("rst_xpos", bus.xpos, 640);
        check("rst_ypos", bus.ypos, 360);
        check("rst_left", bus.left, 0);
        check("rst_right", bus.right, 0);
        check("rst_upd", bus.upd, 0);
        check("rst_err", bus.sync_err, 0);
        check("rst_state", bus.dbg_state, 0);

        // basic packet with latency: byte 2 sampled at edge N, upd after N+1, low after N+2
        send_byte(8'h09);
        send_byte(8'h05);
        send_byte(8'h03);
        check("lat_upd_n", bus.upd, 0);
        check("lat_xpos_n", bus.xpos, 640);
        idle(1);
        check("lat_upd_n1", bus.upd, 1);
        check("pkt_xpos", bus.xpos, 645);
        check("pkt_ypos", bus.ypos, 357);
        check("pkt_left", bus.left, 1);
        check("pkt_right", bus.right, 0);
        idle(1);
        check("lat_upd_n2", bus.upd, 0);
        check("pkt_xpos_hold", bus.xpos, 645);

        // x clamp at 0 with dx = -256
        do_reset();
        send_pkt(8'h18, 8'h00, 8'h00); check("clx_1", bus.xpos, 384);
        send_pkt(8'h18, 8'h00, 8'h00); check("clx_2", bus.xpos, 128);
        send_pkt(8'h18, 8'h00, 8'h00); check("clx_3", bus.xpos, 0);
        send_pkt(8'h18, 8'h00, 8'h00); check("clx_4", bus.xpos, 0);
        check("clx_ypos", bus.ypos, 360);

        // y clamp at YMAX-1: dy = -128 moves the cursor down the screen
        ytab[0] = 12'd488; ytab[1] = 12'd616; ytab[2] = 12'd719; ytab[3] = 12'd719;
        ytab[4] = 12'd719; ytab[5] = 12'd719; ytab[6] = 12'd719; ytab[7] = 12'd719;
        for (int i = 0; i < 8; i++) begin
            send_pkt(8'h28, 8'h00, 8'h80);
            if (i < 3 || i == 7) check($sformatf("cly_%0d", i), bus.ypos, ytab[i]);
        end
        // dy = +128 moves back up
        send_pkt(8'h08, 8'h00, 8'h80); check("cly_up1", bus.ypos, 591);
        send_pkt(8'h08, 8'h00, 8'h80); check("cly_up2", bus.ypos, 463);

        // bad framing byte in WAIT_B0
        do_reset();
        #1;
        upd_base = upd_cnt;
        err_base = err_cnt;
        send_byte(8'h00);
        check("bad_err_pulse", bus.sync_err, 1);
        check("bad_state", bus.dbg_state, 0);
        idle(1);
        check("bad_err_low", bus.sync_err, 0);
        send_pkt(8'h08, 8'h01, 8'h00);
        #1;
        check("bad_xpos", bus.xpos, 641);
        check("bad_upd_cnt", upd_cnt - upd_base, 1);
        check("bad_err_cnt", err_cnt - err_base, 1);

        // timeout after two bytes
        do_reset();
        #1;
        upd_base = upd_cnt;
        err_base = err_cnt;
        send_byte(8'h08);
        send_byte(8'h05);
        for (int i = 1; i <= TOUT + 4; i++) begin
            @(negedge clk100MHz);
            if (bus.sync_err && hit_idx < 0) hit_idx = i;
        end
        check("to_idle_cycle", hit_idx, TOUT);
        check("to_state", bus.dbg_state, 0);
        send_pkt(8'h09, 8'h02, 8'h01);
        #1;
        check("to_xpos", bus.xpos, 642);
        check("to_ypos", bus.ypos, 359);
        check("to_upd_cnt", upd_cnt - upd_base, 1);
        check("to_err_cnt", err_cnt - err_base, 1);

        // overflow packet followed back-to-back by a new packet
        do_reset();
        #1;
        upd_base = upd_cnt;
        err_base = err_cnt;
        send_byte(8'h4A);
        send_byte(8'hFF);
        send_byte(8'h02);
        send_byte(8'h09);
        check("ovf_upd", bus.upd, 1);
        check("ovf_xpos", bus.xpos, 640);
        check("ovf_ypos", bus.ypos, 358);
        check("ovf_right", bus.right, 1);
        check("ovf_left", bus.left, 0);
        send_byte(8'h05);
        send_byte(8'h03);
        idle(1);
        check("b2b_upd", bus.upd, 1);
        check("b2b_xpos", bus.xpos, 645);
        check("b2b_ypos", bus.ypos, 355);
        check("b2b_left", bus.left, 1);
        check("b2b_right", bus.right, 0);
        idle(2);
        #1;
        check("b2b_upd_cnt", upd_cnt - upd_base, 2);
        check("b2b_err_cnt", err_cnt - err_base, 0);

        // reset in mid-packet discards the partial packet
        send_byte(8'h08);
        send_byte(8'h10);
        do_reset();
        check("mid_rst_state", bus.dbg_state, 0);
        send_pkt(8'h08, 8'h01, 8'h01);
        check("mid_rst_xpos", bus.xpos, 641);
        check("mid_rst_ypos", bus.ypos, 359);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end
endmodule
